// File: rtl/hedios_uart_rx.sv
// -----------------------------------------------------------------------------
// hedios_uart_rx
//
// Serial receive front end for the HEDIOS endpoint. Samples the asynchronous
// rx_line and reassembles 8N1 frames into bytes. Each byte goes to a one-entry
// holding register that the frame parser drains through a valid/ready
// handshake. Framing errors and overruns are reported as one-cycle pulses.
//
// Parameters:
//   CLK_RATE   clk frequency in Hz
//   BAUD_RATE  line rate in bit/s (CLK_RATE/BAUD_RATE must be >= 4)
//
// Ports:
//   clk         system clock
//   rst_n       synchronous active-low reset
//   rx_line     asynchronous serial input, idle high
//   data_out    received byte, stable while data_valid is high
//   data_valid  holding register full
//   data_ready  consumer accepts data_out when data_valid && data_ready
//   frame_err   one-cycle pulse: stop bit sampled low
//   overrun     one-cycle pulse: good byte dropped, holding register occupied
// -----------------------------------------------------------------------------
module hedios_uart_rx #(
    parameter int unsigned CLK_RATE  = 100_000_000,
    parameter int unsigned BAUD_RATE = 1_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_line,
    output logic [7:0] data_out,
    output logic       data_valid,
    input  logic       data_ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam int unsigned CPB  = CLK_RATE / BAUD_RATE;
    localparam int unsigned HALF = CPB / 2;
    localparam int unsigned TW   = $clog2(CPB);

    localparam logic [TW-1:0] CPB_M1  = TW'(CPB - 1);
    localparam logic [TW-1:0] HALF_M1 = TW'(HALF - 1);

    generate
        if (CPB < 4) begin : g_cpb_check
            $fatal(1, "hedios_uart_rx: CLK_RATE/BAUD_RATE must be at least 4");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_WAIT_IDLE,
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    // -------------------------------------------------------------------------
    // Input synchronizer (reset to the idle level)
    // -------------------------------------------------------------------------
    logic sync1;
    logic rxs;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            sync1 <= rx_line;
            rxs   <= sync1;
        end
    end

    // The synchronizer holds its reset value of 1 for two clocks after reset
    // releases. If WAIT_IDLE trusted that value it would re-arm in the middle
    // of a frame or a break, so it waits until rxs reflects the real pin.
    logic [1:0] prime;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prime <= '0;
        end else begin
            prime <= {prime[0], 1'b1};
        end
    end

    // -------------------------------------------------------------------------
    // Receive FSM
    // -------------------------------------------------------------------------
    state_t        state;
    logic [TW-1:0] timer;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          stop_good;
    logic          stop_bad;

    // The stop-bit verdict is registered so that data_valid, frame_err and
    // overrun all change on the clock after the stop sample.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_WAIT_IDLE;
            timer     <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            stop_good <= 1'b0;
            stop_bad  <= 1'b0;
        end else begin
            stop_good <= 1'b0;
            stop_bad  <= 1'b0;
            case (state)
                S_WAIT_IDLE: begin
                    if (prime[1] && rxs) begin
                        state <= S_IDLE;
                    end
                end

                S_IDLE: begin
                    if (!rxs) begin
                        state <= S_START;
                        timer <= '0;
                    end
                end

                S_START: begin
                    if (timer == HALF_M1) begin
                        timer <= '0;
                        if (!rxs) begin
                            state   <= S_DATA;
                            bit_idx <= '0;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                S_DATA: begin
                    if (timer == CPB_M1) begin
                        timer <= '0;
                        shift <= {rxs, shift[7:1]};
                        if (bit_idx == 3'd7) begin
                            state <= S_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                S_STOP: begin
                    if (timer == CPB_M1) begin
                        timer <= '0;
                        if (rxs) begin
                            stop_good <= 1'b1;
                            state     <= S_IDLE;
                        end else begin
                            stop_bad <= 1'b1;
                            state    <= S_WAIT_IDLE;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                default: begin
                    state <= S_WAIT_IDLE;
                    timer <= '0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Holding register and error pulses
    // -------------------------------------------------------------------------
    // shift is untouched until the next frame's first data sample, so it still
    // holds the completed byte on the cycle stop_good is high.
    logic xfer;
    assign xfer = data_valid && data_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err <= stop_bad;
            overrun   <= 1'b0;
            if (stop_good) begin
                if (!data_valid || xfer) begin
                    data_out   <= shift;
                    data_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (xfer) begin
                data_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_hedios_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_hedios_uart_rx
//
// Directed bench for hedios_uart_rx at the default 100 MHz / 1 Mbaud
// (100 clocks per bit). A negedge monitor logs transfers and error pulses;
// the linear stimulus block checks those logs against hand-derived values.
// -----------------------------------------------------------------------------
module tb_hedios_uart_rx;

    localparam int unsigned CPB = 100;
    // First edge registering the start bit is frame_start+1; data_valid rises
    // 953 clocks later.
    localparam int LAT = 954;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_line = 1'b1;
    logic       data_ready = 1'b0;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       overrun;

    hedios_uart_rx #(
        .CLK_RATE (100_000_000),
        .BAUD_RATE(1_000_000)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_line   (rx_line),
        .data_out  (data_out),
        .data_valid(data_valid),
        .data_ready(data_ready),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // ---------------- monitor ----------------
    logic [7:0] xq[$];
    int dv_rises = 0, dv_rise_cyc = 0, dv_hi = 0;
    int fe_cnt = 0, fe_cyc = 0, ov_cnt = 0, ov_cyc = 0;
    int wide = 0, both = 0, unstable = 0;
    logic dv_prev = 1'b0, xfer_prev = 1'b0, fe_prev = 1'b0, ov_prev = 1'b0;
    logic [7:0] dout_prev = '0;

    always @(negedge clk) begin
        if (data_valid && !dv_prev) begin
            dv_rises++;
            dv_rise_cyc = cyc;
        end
        if (data_valid) dv_hi++;
        if (data_valid && data_ready) xq.push_back(data_out);
        if (data_valid && dv_prev && !xfer_prev && data_out != dout_prev) unstable++;
        if (frame_err) begin
            fe_cnt++;
            fe_cyc = cyc;
        end
        if (overrun) begin
            ov_cnt++;
            ov_cyc = cyc;
        end
        if ((frame_err && fe_prev) || (overrun && ov_prev)) wide++;
        if (frame_err && overrun) both++;
        dv_prev   = data_valid;
        xfer_prev = data_valid && data_ready;
        fe_prev   = frame_err;
        ov_prev   = overrun;
        dout_prev = data_out;
    end

    // ---------------- helpers ----------------
    int checks = 0;
    int failures = 0;
    int frame_start = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Caller is positioned 1 time unit after a posedge.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        frame_start = cyc;
        for (int i = 0; i < 10; i++) begin
            rx_line = bits[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int r0, x0, f0, o0, h0;

    task automatic snap();
        r0 = dv_rises;
        x0 = xq.size();
        f0 = fe_cnt;
        o0 = ov_cnt;
        h0 = dv_hi;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        step(3);
        chk("reset_data_out", 32'(data_out), 32'h00);
        chk("reset_valid", 32'(data_valid), 32'h0);
        chk("reset_frame_err", 32'(frame_err), 32'h0);
        chk("reset_overrun", 32'(overrun), 32'h0);
        rst_n = 1'b1;
        step(10);

        // Single byte, consumer always ready
        data_ready = 1'b1;
        snap();
        send_frame(8'hA5, 1'b1);
        step(20);
        chk("a5_rises", 32'(dv_rises - r0), 32'd1);
        chk("a5_latency", 32'(dv_rise_cyc - frame_start), 32'(LAT));
        chk("a5_valid_width", 32'(dv_hi - h0), 32'd1);
        chk("a5_xfers", 32'(xq.size() - x0), 32'd1);
        chk("a5_byte", 32'(xq[$]), 32'hA5);
        chk("a5_no_errs", 32'((fe_cnt - f0) + (ov_cnt - o0)), 32'd0);
        chk("a5_valid_low", 32'(data_valid), 32'h0);

        // Overrun: two back-to-back frames with consumer stalled
        data_ready = 1'b0;
        snap();
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        step(20);
        chk("ovr_pulses", 32'(ov_cnt - o0), 32'd1);
        chk("ovr_timing", 32'(ov_cyc - frame_start), 32'(LAT));
        chk("ovr_valid", 32'(data_valid), 32'h1);
        chk("ovr_data_kept", 32'(data_out), 32'h00);
        chk("ovr_no_xfer", 32'(xq.size() - x0), 32'd0);
        chk("ovr_no_ferr", 32'(fe_cnt - f0), 32'd0);
        data_ready = 1'b1;
        step(1);
        data_ready = 1'b0;
        step(3);
        chk("ovr_drain_count", 32'(xq.size() - x0), 32'd1);
        chk("ovr_drain_byte", 32'(xq[$]), 32'h00);
        chk("ovr_valid_fell", 32'(data_valid), 32'h0);

        // Same-cycle transfer and load
        send_frame(8'h12, 1'b1);
        step(10);
        chk("sc_pending_valid", 32'(data_valid), 32'h1);
        chk("sc_pending_byte", 32'(data_out), 32'h12);
        snap();
        fork
            send_frame(8'h34, 1'b1);
            begin
                step(LAT - 1);
                data_ready = 1'b1;
                step(1);
                data_ready = 1'b0;
            end
        join
        step(5);
        chk("sc_xfer_count", 32'(xq.size() - x0), 32'd1);
        chk("sc_xfer_byte", 32'(xq[$]), 32'h12);
        chk("sc_no_overrun", 32'(ov_cnt - o0), 32'd0);
        chk("sc_valid_held", 32'(data_valid), 32'h1);
        chk("sc_new_byte", 32'(data_out), 32'h34);
        data_ready = 1'b1;
        step(1);
        data_ready = 1'b0;
        step(2);
        chk("sc_drain_byte", 32'(xq[$]), 32'h34);
        chk("sc_drain_valid", 32'(data_valid), 32'h0);

        // Framing error followed by a long break
        snap();
        send_frame(8'h55, 1'b0);
        step(2000);
        chk("fe_pulses", 32'(fe_cnt - f0), 32'd1);
        chk("fe_timing", 32'(fe_cyc - frame_start), 32'(LAT));
        chk("fe_no_valid", 32'(dv_rises - r0), 32'd0);
        rx_line = 1'b1;
        step(50);
        data_ready = 1'b1;
        send_frame(8'h3C, 1'b1);
        step(20);
        chk("fe_recover_byte", 32'(xq[$]), 32'h3C);
        chk("fe_recover_rises", 32'(dv_rises - r0), 32'd1);
        chk("fe_no_extra", 32'(fe_cnt - f0), 32'd1);

        // Start-bit glitch
        snap();
        rx_line = 1'b0;
        step(20);
        rx_line = 1'b1;
        step(200);
        chk("gl_no_valid", 32'(dv_rises - r0), 32'd0);
        chk("gl_no_ferr", 32'(fe_cnt - f0), 32'd0);
        send_frame(8'h5A, 1'b1);
        step(20);
        chk("gl_next_byte", 32'(xq[$]), 32'h5A);
        chk("gl_next_rises", 32'(dv_rises - r0), 32'd1);

        // Reset in the middle of a frame while the line is low
        snap();
        fork
            send_frame(8'h00, 1'b1);
            begin
                step(400);
                rst_n = 1'b0;
                step(3);
                rst_n = 1'b1;
            end
        join
        step(20);
        chk("rst_no_valid", 32'(dv_rises - r0), 32'd0);
        chk("rst_no_errs", 32'((fe_cnt - f0) + (ov_cnt - o0)), 32'd0);
        send_frame(8'h81, 1'b1);
        step(20);
        chk("rst_next_byte", 32'(xq[$]), 32'h81);
        chk("rst_next_rises", 32'(dv_rises - r0), 32'd1);

        // Global properties over the whole run
        chk("pulse_width", 32'(wide), 32'd0);
        chk("pulse_overlap", 32'(both), 32'd0);
        chk("data_stable", 32'(unstable), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
